lfsr_seq_checker: RTL and testbench

Receive-side checker for the 5-bit Fibonacci LFSR random-number stream produced elsewhere in the PBS design. It accepts one LFSR word per valid strobe, self-synchronises to the sequence, and then predicts every following word. Mismatches are counted as word errors and bit errors. It sits at the consumer end of the RNG, as a link/integrity monitor, and its counts can be driven onto the hex displays.

---
 rtl/lfsr_seq_checker_pkg.sv | 18 +
 rtl/lfsr_seq_checker_if.sv | 25 ++
 rtl/lfsr_popcount.sv | 14 +
 rtl/lfsr_seq_checker.sv | 130 +++++++++++++
 tb/tb_lfsr_seq_checker.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/lfsr_seq_checker_pkg.sv
// Definitions shared by the PBS 5-bit LFSR generator and its receive-side checker.
package pbs_lfsr_pkg;

  localparam int              LFSR_W     = 5;
  localparam logic [LFSR_W-1:0] RESET_SEED = 5'h1F;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Shared step so generator and checker cannot drift apart.
  function automatic logic [LFSR_W-1:0] lfsr5_next(input logic [LFSR_W-1:0] d);
    return {d[4] ^ d[1], d[4:1]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Word stream in, lock status and error counters out, for the LFSR sequence checker.
interface lfsr_seq_checker_if #(
  parameter int CNT_W = 16
);
  import pbs_lfsr_pkg::*;

  logic              in_valid;
  logic [LFSR_W-1:0] in_data;
  logic              clr_cnt;
  logic              locked;
  logic              err_pulse;
  logic [CNT_W-1:0]  word_err_cnt;
  logic [CNT_W-1:0]  bit_err_cnt;

  modport master (
    output in_valid, in_data, clr_cnt,
    input  locked, err_pulse, word_err_cnt, bit_err_cnt
  );

  modport slave (
    input  in_valid, in_data, clr_cnt,
    output locked, err_pulse, word_err_cnt, bit_err_cnt
  );

endinterface

// File: rtl/lfsr_popcount.sv
// Population count of a 5-bit word; used to size bit errors per mismatched word.
module lfsr_popcount (
  input  logic [4:0] d_i,
  output logic [2:0] cnt_o
);

  always_comb begin
    cnt_o = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cnt_o = cnt_o + {2'b00, d_i[i]};
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the PBS 5-bit LFSR stream with saturating error counters.
//   state  | meaning
//   HUNT   | waiting for a non-zero word to seed the prediction
//   ACQ    | seeded; counting consecutive correct predictions toward lock
//   LOCKED | prediction free-runs; mismatches are counted as errors
module lfsr_seq_checker
  import pbs_lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lfsr_seq_checker_if.slave chk
);

  localparam logic [2:0]       LOCK_N  = 3'(LOCK_COUNT);
  localparam logic [2:0]       MISS_N  = 3'(MISS_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [2:0]        match_q, match_d;
  logic [2:0]        miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]  bit_q, bit_d;

  logic [2:0]        diff_bits;
  logic [2:0]        match_inc, miss_inc;
  logic [CNT_W+2:0]  bit_sum;

  lfsr_popcount u_popcount (
    .d_i   (chk.in_data ^ pred_q),
    .cnt_o (diff_bits)
  );

  assign match_inc = match_q + 3'd1;
  assign miss_inc  = miss_q + 3'd1;
  assign bit_sum   = {3'b000, bit_q} + {{CNT_W{1'b0}}, diff_bits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    word_d  = word_q;
    bit_d   = bit_q;

    if (chk.in_valid) begin
      case (state_q)
        HUNT: begin
          if (chk.in_data != '0) begin
            pred_d  = lfsr5_next(chk.in_data);
            match_d = '0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (chk.in_data == pred_q) begin
            pred_d  = lfsr5_next(chk.in_data);
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (chk.in_data != '0) begin
            pred_d  = lfsr5_next(chk.in_data);
            match_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Never reseed from the input here: a corrupted word must not steer the prediction.
          pred_d = lfsr5_next(pred_q);
          if (chk.in_data == pred_q) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (word_q != CNT_MAX) word_d = word_q + CNT_W'(1);
            if (bit_sum > {3'b000, CNT_MAX}) bit_d = CNT_MAX;
            else                             bit_d = bit_sum[CNT_W-1:0];
            if (miss_inc == MISS_N) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (chk.clr_cnt) begin
      word_d = '0;
      bit_d  = '0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  assign chk.locked       = locked_q;
  assign chk.err_pulse    = err_q;
  assign chk.word_err_cnt = word_q;
  assign chk.bit_err_cnt  = bit_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed scoreboard bench for lfsr_seq_checker, run with 4-bit counters to reach saturation.
module tb_lfsr_seq_checker;

  localparam int CNT_W = 4;

  typedef struct {
    int               id;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] word;
    logic [CNT_W-1:0] bits;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   step_id;

  lfsr_seq_checker_if #(.CNT_W(CNT_W)) bus ();

  lfsr_seq_checker #(
    .LOCK_COUNT (3),
    .MISS_LIMIT (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .chk   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] nxt(input logic [4:0] d);
    logic [4:0] r;
    r    = d >> 1;
    r[4] = d[4] ^ d[1];
    return r;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, want %0h", name, id, got, want);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] d, input logic clr,
                      input logic l, input logic e, input int w, input int b);
    exp_t x;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clr_cnt  = clr;
    step_id++;
    x.id     = step_id;
    x.locked = l;
    x.err    = e;
    x.word   = CNT_W'(w);
    x.bits   = CNT_W'(b);
    exp_q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 5'h00;
    bus.clr_cnt  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: the DUT presents a registered response one edge after each driven cycle.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      check("locked",       x.id, 32'(bus.locked),       32'(x.locked));
      check("err_pulse",    x.id, 32'(bus.err_pulse),    32'(x.err));
      check("word_err_cnt", x.id, 32'(bus.word_err_cnt), 32'(x.word));
      check("bit_err_cnt",  x.id, 32'(bus.bit_err_cnt),  32'(x.bits));
    end
  end

  task automatic lock_seq();
    step(1'b1, 5'h1F, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'h0F, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'h17, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 5'h0B, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    logic [4:0] p;
    int w;
    int b;
    checks       = 0;
    errors       = 0;
    step_id      = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 5'h00;
    bus.clr_cnt  = 1'b0;
    rst_n        = 1'b0;
    #12;
    check("reset_locked", 0, 32'(bus.locked),       32'd0);
    check("reset_err",    0, 32'(bus.err_pulse),    32'd0);
    check("reset_word",   0, 32'(bus.word_err_cnt), 32'd0);
    check("reset_bit",    0, 32'(bus.bit_err_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    lock_seq();

    // expected 15: one flipped bit, then back on sequence
    step(1'b1, 5'h14, 1'b0, 1'b1, 1'b1, 1, 1);
    step(1'b1, 5'h1A, 1'b0, 1'b1, 1'b0, 1, 1);

    step(1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 0, 0);

    // zeros against predictions 0D, 06, 13, 09
    step(1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 1, 3);
    step(1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 2, 5);
    step(1'b1, 5'h00, 1'b0, 1'b1, 1'b1, 3, 8);
    step(1'b1, 5'h00, 1'b0, 1'b0, 1'b1, 4, 10);
    step(1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b1, 5'h00, 1'b0, 1'b0, 1'b0, 4, 10);

    // gaps carry garbage data that must not disturb acquisition
    step(1'b1, 5'h1F, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b0, 5'h05, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b1, 5'h0F, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b0, 5'h1B, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b1, 5'h17, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 4, 10);
    step(1'b1, 5'h0B, 1'b0, 1'b1, 1'b0, 4, 10);
    step(1'b0, 5'h1F, 1'b0, 1'b1, 1'b0, 4, 10);
    step(1'b1, 5'h15, 1'b0, 1'b1, 1'b0, 4, 10);
    step(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 4, 10);
    step(1'b1, 5'h1A, 1'b0, 1'b1, 1'b0, 4, 10);

    step(1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 0, 0);
    p = 5'h0D;
    w = 0;
    b = 0;
    for (int i = 0; i < 20; i++) begin
      w = (w < 15) ? w + 1 : 15;
      b = (b < 15) ? b + 1 : 15;
      step(1'b1, p ^ 5'h01, 1'b0, 1'b1, 1'b1, w, b);
      p = nxt(p);
      step(1'b1, p, 1'b0, 1'b1, 1'b0, w, b);
      p = nxt(p);
    end

    step(1'b1, p ^ 5'h01, 1'b1, 1'b1, 1'b1, 0, 0);
    p = nxt(p);
    step(1'b1, p ^ 5'h03, 1'b0, 1'b1, 1'b1, 1, 2);
    idle();
    drain();

    #2;
    rst_n = 1'b0;
    #1;
    check("async_locked", -1, 32'(bus.locked),       32'd0);
    check("async_err",    -1, 32'(bus.err_pulse),    32'd0);
    check("async_word",   -1, 32'(bus.word_err_cnt), 32'd0);
    check("async_bit",    -1, 32'(bus.bit_err_cnt),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lock_seq();
    step(1'b1, 5'h15, 1'b0, 1'b1, 1'b0, 0, 0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
